// File: rtl/window_scan_ctrl_pkg.sv
// Shared types and helpers for the window scan controller and its address generator.
package window_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] EOT_NONE = 2'b00;
  localparam logic [1:0] EOT_ROW  = 2'b01;
  localparam logic [1:0] EOT_WIN  = 2'b11;

  // Largest origin a window can take along one axis; 0 when the window does not fit.
  function automatic int last_origin(input int img, input int win, input int step);
    if (win > img || step < 1) return 0;
    return ((img - win) / step) * step;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Walks the rows/columns of one window and produces integral-image addresses with eot tags.
module window_addr_gen
  import window_scan_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH     = 48,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  parameter int W_ADDR        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W_ADDR-1:0] base,
  input  logic              advance,
  output logic [W_ADDR-1:0] addr,
  output logic [1:0]        eot
);

  localparam int CW = (WINDOW_WIDTH  > 1) ? $clog2(WINDOW_WIDTH)  : 1;
  localparam int RW = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;
  localparam logic [W_ADDR-1:0] ROW_PITCH = W_ADDR'(IMG_WIDTH);

  logic [CW-1:0]     c_reg;
  logic [RW-1:0]     r_reg;
  logic [W_ADDR-1:0] row_base_reg;
  logic [W_ADDR-1:0] addr_reg;
  logic              last_col;
  logic              last_row;

  assign last_col = (c_reg == CW'(WINDOW_WIDTH - 1));
  assign last_row = (r_reg == RW'(WINDOW_HEIGHT - 1));

  // Address tracks row_base + c incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg        <= '0;
      r_reg        <= '0;
      row_base_reg <= '0;
      addr_reg     <= '0;
    end else if (load) begin
      c_reg        <= '0;
      r_reg        <= '0;
      row_base_reg <= base;
      addr_reg     <= base;
    end else if (advance) begin
      if (last_col) begin
        c_reg        <= '0;
        r_reg        <= last_row ? '0 : r_reg + 1'b1;
        row_base_reg <= row_base_reg + ROW_PITCH;
        addr_reg     <= row_base_reg + ROW_PITCH;
      end else begin
        c_reg    <= c_reg + 1'b1;
        addr_reg <= addr_reg + 1'b1;
      end
    end
  end

  assign addr = addr_reg;
  assign eot  = last_col ? (last_row ? EOT_WIN : EOT_ROW) : EOT_NONE;

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame-level scan FSM: steps the window origin in raster order and hands each window to the address generator.
module window_scan_ctrl
  import window_scan_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH     = 48,
  parameter int IMG_HEIGHT    = 48,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  parameter int STEP          = 1,
  parameter int W_ADDR        = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int XW           = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW           = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [W_ADDR-1:0] addr_data,
  output logic [1:0]        addr_eot,
  output logic [XW-1:0]     win_x,
  output logic [YW-1:0]     win_y,
  input  logic              res_valid,
  output logic              res_ready
);

  localparam bit DEGENERATE = (WINDOW_WIDTH > IMG_WIDTH) || (WINDOW_HEIGHT > IMG_HEIGHT);
  localparam int LAST_X     = last_origin(IMG_WIDTH, WINDOW_WIDTH, STEP);
  localparam int LAST_Y     = last_origin(IMG_HEIGHT, WINDOW_HEIGHT, STEP);
  localparam logic [W_ADDR-1:0] X_STEP   = W_ADDR'(STEP);
  localparam logic [W_ADDR-1:0] ROW_STEP = W_ADDR'(STEP * IMG_WIDTH);

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [W_ADDR-1:0] origin_reg, origin_next;
  logic [W_ADDR-1:0] row_origin_reg, row_origin_next;
  logic              gen_load;
  logic              gen_advance;
  logic [W_ADDR-1:0] gen_base;
  logic [W_ADDR-1:0] gen_addr;
  logic [1:0]        gen_eot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      origin_reg     <= '0;
      row_origin_reg <= '0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      origin_reg     <= origin_next;
      row_origin_reg <= row_origin_next;
    end
  end

  // origin_reg is y*IMG_WIDTH + x, kept by accumulation alongside x/y.
  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    origin_next     = origin_reg;
    row_origin_next = row_origin_reg;
    gen_load        = 1'b0;
    gen_base        = origin_reg;
    gen_advance     = (state_reg == STREAM) && addr_ready;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (DEGENERATE) begin
            state_next = DONE;
          end else begin
            state_next      = STREAM;
            x_next          = '0;
            y_next          = '0;
            origin_next     = '0;
            row_origin_next = '0;
            gen_load        = 1'b1;
            gen_base        = '0;
          end
        end
      end
      STREAM: begin
        if (addr_ready && gen_eot == EOT_WIN) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) begin
          if (int'(x_reg) < LAST_X) begin
            x_next      = x_reg + XW'(STEP);
            origin_next = origin_reg + X_STEP;
            state_next  = STREAM;
            gen_load    = 1'b1;
          end else if (int'(y_reg) < LAST_Y) begin
            x_next          = '0;
            y_next          = y_reg + YW'(STEP);
            row_origin_next = row_origin_reg + ROW_STEP;
            origin_next     = row_origin_reg + ROW_STEP;
            state_next      = STREAM;
            gen_load        = 1'b1;
          end else begin
            state_next = DONE;
          end
          gen_base = origin_next;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  window_addr_gen #(
    .IMG_WIDTH    (IMG_WIDTH),
    .WINDOW_WIDTH (WINDOW_WIDTH),
    .WINDOW_HEIGHT(WINDOW_HEIGHT),
    .W_ADDR       (W_ADDR)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (gen_load),
    .base   (gen_base),
    .advance(gen_advance),
    .addr   (gen_addr),
    .eot    (gen_eot)
  );

  assign busy       = (state_reg == STREAM) || (state_reg == WAIT_RES);
  assign done       = (state_reg == DONE);
  assign addr_valid = (state_reg == STREAM);
  assign res_ready  = (state_reg == WAIT_RES);
  assign addr_data  = gen_addr;
  assign addr_eot   = (state_reg == STREAM) ? gen_eot : EOT_NONE;
  assign win_x      = x_reg;
  assign win_y      = y_reg;

endmodule
